seg_addsub_pipe: RTL and testbench
==================================

# seg_addsub_pipe

Pipelined, parametrised lane-segmented adder/subtractor for the correlated-randomness datapath. It generalises the fixed 32/64/128/256-bit carry-mask scheme to any power-of-two lane width that is a multiple of `CHUNK_W`. The carry chain is split across `NUM_STAGES` registered stages with valid/ready flow control. It sits between the PRNG expansion output and the CR share formatter, combining PRNG words into additive shares and counting completed operations.

## Interface
- `DATA_W`, 256, operand/result width; power of two, multiple of `CHUNK_W`.
- `CHUNK_W`, 32, carry-mask granularity; the minimum lane width.
- `NUM_STAGES`, 4, number of pipeline stages; must divide `DATA_W/CHUNK_W`.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `in_valid_i` in 1: operand beat valid.
- `in_ready_o` out 1: block accepts a beat this cycle.
- `a_i` in `DATA_W`: operand A.
- `b_i` in `DATA_W`: operand B.
- `lane_log_i` in `$clog2(DATA_W/CHUNK_W)+1`: lane width = `CHUNK_W << lane_log_i`.
- `sub_i` in 1: 0 = A+B, 1 = A−B per lane.
- `out_valid_o` out 1: result valid.
- `out_ready_i` in 1: downstream accepts the result.
- `sum_o` out `DATA_W`: per-lane result.
- `carry_o` out `DATA_W/CHUNK_W`: bit i = carry-out of chunk i if chunk i is the top chunk of a lane, else 0.
- `cr_cnt_o` out `LEN_MAX_CR` (32): count of results delivered.

## Operation
- Chunk i (bits `[i*CHUNK_W +: CHUNK_W]`) receives carry-in from chunk i−1 only if i is not a lane boundary, i.e. `i % (1<<lane_log) != 0`. At a lane boundary the carry-in is forced to `sub`.
- Subtract: B is inverted per chunk and carry-in 1 is injected at each lane's low chunk. For subtraction, `carry_o` = 1 means no borrow.
- If `lane_log_i` exceeds `$clog2(DATA_W/CHUNK_W)`, it is clamped to that value (single full-width lane).
- Stage s computes chunks `[s*G, (s+1)*G)` with `G = (DATA_W/CHUNK_W)/NUM_STAGES`, using the carry registered from stage s−1.
- Unprocessed operand chunks, `lane_log` and `sub` travel with the beat. Completed result chunks are carried forward in the stage registers.
- Results are all-modular per lane (wrap mod 2^lane width). No saturation.
- `cr_cnt_o` increments on every `out_valid_o && out_ready_i` and wraps from 2^32−1 to 0.

## Timing
- Latency: a beat accepted at cycle t is presented at `out_valid_o` in cycle t+`NUM_STAGES`, with no stall.
- Throughput: one beat per cycle.
- Global stall: `in_ready_o = !(out_valid_o && !out_ready_i)`. While stalled, all stage registers hold, and `sum_o`/`carry_o` are stable with `out_valid_o` held high.
- Bubbles propagate as invalid stage slots. There is no compaction; a bubble does not block upstream when the output is not stalled.
- Simultaneous accept and deliver in the same cycle are allowed. The count updates once.
- Reset: all stage valids 0, `out_valid_o`=0, `sum_o`=0, `carry_o`=0, `cr_cnt_o`=0, `in_ready_o`=1 after reset. Assertion mid-operation discards all in-flight beats immediately and asynchronously.
- Input data is sampled only when `in_valid_i && in_ready_o`.

## Configuration
- `SEG_ADDSUB_SUB_EN`
  - Defined: subtraction path present as described.
  - Undefined: `sub_i` is ignored (treated 0), no inverters or injected carries are built, the `sub` bit is not pipelined, and the block is add-only.

## Structure
- Shared package `TYPES`: add `lane_log_t`, a stage-payload struct (valid, remaining A/B, partial sum, carry, lane_log, sub), and a `make_lane_carry_mask(lane_log)` function returning the per-chunk boundary mask. `cr_cnt_t` is reused for the counter.
- One sub-module: `seg_addsub_stage`, which handles one stage of G chunks, its mask slice and carry in/out. The top instantiates `NUM_STAGES` copies plus the handshake and counter logic.

## Test plan
- Full width, add: `lane_log`=3, A=2^256−1, B=1 → `sum_o`=0, `carry_o`=0x80, latency exactly 4 cycles.
- 32-bit lanes, add: `lane_log`=0, A=all 0xFFFFFFFF, B=all 0x00000001 → all lanes 0, `carry_o`=0xFF; no cross-lane carry.
- 64-bit lanes, subtract (macro on): A=0, B=1 per lane → each lane 0xFFFFFFFFFFFFFFFF, `carry_o`=0x00. With the macro off, the same stimulus gives each lane = 1.
- Back-pressure: stream 10 random beats with mixed `lane_log`, hold `out_ready_i`=0 for 5 cycles mid-stream → `in_ready_o` drops, no beat lost or duplicated, results match the model, `cr_cnt_o`=10.
- Reset mid-stream: 3 beats in flight, pulse `rst_n` low → `out_valid_o`=0, `cr_cnt_o`=0, and no stale result appears afterwards.
- Counter wrap: force the count to 0xFFFFFFFF via 2^32−1 deliveries (backdoor preload), deliver one more → `cr_cnt_o`=0. Also check that `lane_log`=7 behaves as `lane_log`=3.

Source files
------------

// File: rtl/seg_addsub_pipe_pkg.sv
// Shared types and helpers for the lane-segmented pipelined adder/subtractor.
package seg_addsub_pipe_pkg;

  localparam int LEN_MAX_CR     = 32;
  localparam int DEF_DATA_W     = 256;
  localparam int DEF_CHUNK_W    = 32;
  localparam int DEF_NUM_CHUNKS = DEF_DATA_W / DEF_CHUNK_W;
  localparam int DEF_LANE_LOG_W = $clog2(DEF_NUM_CHUNKS) + 1;
  localparam int MAX_CHUNKS     = 128;

  typedef logic [LEN_MAX_CR-1:0]     cr_cnt_t;
  typedef logic [DEF_LANE_LOG_W-1:0] lane_log_t;

  // Payload carried by one stage slot in the default 256/32 geometry.
  typedef struct packed {
    logic                      vld;
    logic [DEF_DATA_W-1:0]     a;
    logic [DEF_DATA_W-1:0]     b;
    logic [DEF_DATA_W-1:0]     sum;
    logic [DEF_NUM_CHUNKS-1:0] carry;
    lane_log_t                 lane_log;
    logic                      sub;
  } stage_payload_t;

  // Bit i set when chunk i is the low chunk of a lane (carry-in is not chained).
  function automatic logic [MAX_CHUNKS-1:0] make_lane_carry_mask(input int unsigned lane_log);
    logic [MAX_CHUNKS-1:0] m;
    int unsigned           span;
    m    = '0;
    span = 32'd1 << lane_log;
    for (int unsigned i = 0; i < MAX_CHUNKS; i++) begin
      m[i] = ((i % span) == 0);
    end
    return m;
  endfunction

endpackage

// File: rtl/seg_addsub_stage.sv
// One carry-chain segment: G consecutive chunks of the lane-segmented adder.
// Build option SEG_ADDSUB_SUB_EN adds the per-lane subtract path.
module seg_addsub_stage
  import seg_addsub_pipe_pkg::*;
#(
  parameter int DATA_W     = 256,
  parameter int CHUNK_W    = 32,
  parameter int NUM_STAGES = 4,
  parameter int STAGE_IDX  = 0,
  parameter int LL_W       = 4
) (
  input  logic [LL_W-1:0]             lane_log,
`ifdef SEG_ADDSUB_SUB_EN
  input  logic                        sub,
`endif
  input  logic                        carry_in,
  input  logic [DATA_W-1:0]           a,
  input  logic [DATA_W-1:0]           b,
  input  logic [DATA_W-1:0]           sum_in,
  input  logic [DATA_W/CHUNK_W-1:0]   cout_in,
  output logic [DATA_W-1:0]           sum_out,
  output logic [DATA_W/CHUNK_W-1:0]   cout_out,
  output logic                        carry_out
);

  localparam int NCH  = DATA_W / CHUNK_W;
  localparam int G    = NCH / NUM_STAGES;
  localparam int BASE = STAGE_IDX * G;

  logic [MAX_CHUNKS-1:0] mask;
  logic                  c;
  logic                  cin;
  logic [CHUNK_W-1:0]    bb;
  logic [CHUNK_W-1:0]    r;

  // Ripple through this stage's chunks, breaking the chain at lane boundaries.
  always_comb begin
    mask     = make_lane_carry_mask(32'(lane_log));
    sum_out  = sum_in;
    cout_out = cout_in;
    c        = carry_in;
    cin      = 1'b0;
    bb       = '0;
    r        = '0;
    for (int j = 0; j < G; j++) begin
`ifdef SEG_ADDSUB_SUB_EN
      cin = mask[BASE+j] ? sub : c;
      bb  = sub ? ~b[(BASE+j)*CHUNK_W +: CHUNK_W] : b[(BASE+j)*CHUNK_W +: CHUNK_W];
`else
      cin = mask[BASE+j] ? 1'b0 : c;
      bb  = b[(BASE+j)*CHUNK_W +: CHUNK_W];
`endif
      {c, r} = {1'b0, a[(BASE+j)*CHUNK_W +: CHUNK_W]} + {1'b0, bb} + {{CHUNK_W{1'b0}}, cin};
      sum_out[(BASE+j)*CHUNK_W +: CHUNK_W] = r;
      cout_out[BASE+j] = (((BASE+j) == NCH-1) || mask[BASE+j+1]) ? c : 1'b0;
    end
    carry_out = c;
  end

endmodule

// File: rtl/seg_addsub_pipe.sv
// Pipelined lane-segmented adder/subtractor with valid/ready flow control and
// a delivered-result counter. Build option SEG_ADDSUB_SUB_EN enables A-B.
module seg_addsub_pipe
  import seg_addsub_pipe_pkg::*;
#(
  parameter int DATA_W     = 256,
  parameter int CHUNK_W    = 32,
  parameter int NUM_STAGES = 4
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                in_valid_i,
  output logic                                in_ready_o,
  input  logic [DATA_W-1:0]                   a_i,
  input  logic [DATA_W-1:0]                   b_i,
  input  logic [$clog2(DATA_W/CHUNK_W):0]     lane_log_i,
  input  logic                                sub_i,
  output logic                                out_valid_o,
  input  logic                                out_ready_i,
  output logic [DATA_W-1:0]                   sum_o,
  output logic [DATA_W/CHUNK_W-1:0]           carry_o,
  output cr_cnt_t                             cr_cnt_o
);

  localparam int NCH     = DATA_W / CHUNK_W;
  localparam int LOG_NCH = $clog2(NCH);
  localparam int LL_W    = LOG_NCH + 1;

  logic            adv;
  logic [LL_W-1:0] ll_clamped;
  cr_cnt_t         cr_cnt_q;

  // Stage registers (index s = output of stage s).
  logic             vld_p [NUM_STAGES];
  logic [DATA_W-1:0] a_p  [NUM_STAGES];
  logic [DATA_W-1:0] b_p  [NUM_STAGES];
  logic [DATA_W-1:0] sum_p[NUM_STAGES];
  logic [NCH-1:0]    cy_p [NUM_STAGES];
  logic [LL_W-1:0]   ll_p [NUM_STAGES];
  logic              c_p  [NUM_STAGES];
  logic              sub_p[NUM_STAGES];

  // Stage inputs and combinational results.
  logic              in_vld[NUM_STAGES];
  logic [DATA_W-1:0] in_a  [NUM_STAGES];
  logic [DATA_W-1:0] in_b  [NUM_STAGES];
  logic [DATA_W-1:0] in_sum[NUM_STAGES];
  logic [NCH-1:0]    in_cy [NUM_STAGES];
  logic [LL_W-1:0]   in_ll [NUM_STAGES];
  logic              in_c  [NUM_STAGES];
  logic              in_sub[NUM_STAGES];
  logic [DATA_W-1:0] sum_n [NUM_STAGES];
  logic [NCH-1:0]    cy_n  [NUM_STAGES];
  logic              c_n   [NUM_STAGES];

  assign out_valid_o = vld_p[NUM_STAGES-1];
  assign sum_o       = sum_p[NUM_STAGES-1];
  assign carry_o     = cy_p[NUM_STAGES-1];
  assign cr_cnt_o    = cr_cnt_q;
  assign adv         = !(out_valid_o && !out_ready_i);
  assign in_ready_o  = adv;
  assign ll_clamped  = (lane_log_i > LL_W'(LOG_NCH)) ? LL_W'(LOG_NCH) : lane_log_i;

  for (genvar s = 0; s < NUM_STAGES; s++) begin : g_stage
    if (s == 0) begin : g_first
      assign in_vld[s] = in_valid_i;
      assign in_a[s]   = a_i;
      assign in_b[s]   = b_i;
      assign in_sum[s] = '0;
      assign in_cy[s]  = '0;
      assign in_ll[s]  = ll_clamped;
      assign in_c[s]   = 1'b0;
`ifdef SEG_ADDSUB_SUB_EN
      assign in_sub[s] = sub_i;
`else
      assign in_sub[s] = 1'b0;
`endif
    end else begin : g_rest
      assign in_vld[s] = vld_p[s-1];
      assign in_a[s]   = a_p[s-1];
      assign in_b[s]   = b_p[s-1];
      assign in_sum[s] = sum_p[s-1];
      assign in_cy[s]  = cy_p[s-1];
      assign in_ll[s]  = ll_p[s-1];
      assign in_c[s]   = c_p[s-1];
      assign in_sub[s] = sub_p[s-1];
    end

    seg_addsub_stage #(
      .DATA_W     (DATA_W),
      .CHUNK_W    (CHUNK_W),
      .NUM_STAGES (NUM_STAGES),
      .STAGE_IDX  (s),
      .LL_W       (LL_W)
    ) u_stage (
      .lane_log  (in_ll[s]),
`ifdef SEG_ADDSUB_SUB_EN
      .sub       (in_sub[s]),
`endif
      .carry_in  (in_c[s]),
      .a         (in_a[s]),
      .b         (in_b[s]),
      .sum_in    (in_sum[s]),
      .cout_in   (in_cy[s]),
      .sum_out   (sum_n[s]),
      .cout_out  (cy_n[s]),
      .carry_out (c_n[s])
    );

    // Stage valid and visible result fields; cleared on reset, held on stall.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_p[s] <= 1'b0;
        sum_p[s] <= '0;
        cy_p[s]  <= '0;
      end else if (adv) begin
        vld_p[s] <= in_vld[s];
        if (in_vld[s]) begin
          sum_p[s] <= sum_n[s];
          cy_p[s]  <= cy_n[s];
        end
      end
    end

    // Operands, lane config and chain carry travel with the beat.
    always_ff @(posedge clk) begin
      if (adv && in_vld[s]) begin
        a_p[s]   <= in_a[s];
        b_p[s]   <= in_b[s];
        ll_p[s]  <= in_ll[s];
        c_p[s]   <= c_n[s];
        sub_p[s] <= in_sub[s];
      end
    end
  end

  // Count delivered results; wraps naturally at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cr_cnt_q <= '0;
    end else if (out_valid_o && out_ready_i) begin
      cr_cnt_q <= cr_cnt_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_seg_addsub_pipe.sv
// Scoreboard bench for seg_addsub_pipe (default 256/32/4 geometry).
module tb_seg_addsub_pipe;

`ifdef SEG_ADDSUB_SUB_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid_i;
  logic         in_ready_o;
  logic [255:0] a_i, b_i;
  logic [3:0]   lane_log_i;
  logic         sub_i;
  logic         out_valid_o;
  logic         out_ready_i;
  logic [255:0] sum_o;
  logic [7:0]   carry_o;
  logic [31:0]  cr_cnt_o;

  typedef struct {
    logic [255:0] sum;
    logic [7:0]   cy;
    int           acc;
    bit           chk_lat;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  seg_addsub_pipe dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .a_i         (a_i),
    .b_i         (b_i),
    .lane_log_i  (lane_log_i),
    .sub_i       (sub_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .sum_o       (sum_o),
    .carry_o     (carry_o),
    .cr_cnt_o    (cr_cnt_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference: whole-lane arithmetic, independent of chunking.
  task automatic model(input logic [255:0] a, input logic [255:0] b, input int ll, input bit s,
                       output logic [255:0] sum, output logic [7:0] cy);
    int           l, lw, nl;
    logic [256:0] m, al, bl, r;
    bit           se, carry;
    l   = (ll > 3) ? 3 : ll;
    lw  = 32 << l;
    nl  = 256 / lw;
    se  = s & SUB_EN;
    m   = (257'd1 << lw) - 257'd1;
    sum = '0;
    cy  = '0;
    for (int k = 0; k < nl; k++) begin
      al = ({1'b0, a} >> (k*lw)) & m;
      bl = ({1'b0, b} >> (k*lw)) & m;
      if (se) begin
        carry = (al >= bl);
        r     = (al - bl) & m;
      end else begin
        r     = al + bl;
        carry = r[lw];
        r     = r & m;
      end
      sum = sum | 256'(r << (k*lw));
      cy[(k+1)*(lw/32)-1] = carry;
    end
  endtask

  task automatic send(input logic [255:0] a, input logic [255:0] b, input logic [3:0] ll,
                      input bit s, input logic [255:0] es, input logic [7:0] ec, input bit lat);
    int   n;
    exp_t e;
    a_i = a; b_i = b; lane_log_i = ll; sub_i = s; in_valid_i = 1'b1;
    @(negedge clk);
    n = 0;
    while (!in_ready_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready_o) begin
      check("accept_timeout", 256'(in_ready_o), 256'(1));
    end else begin
      e.sum = es; e.cy = ec; e.acc = cyc; e.chk_lat = lat;
      sbq.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_m(input logic [255:0] a, input logic [255:0] b, input logic [3:0] ll, input bit s);
    logic [255:0] es;
    logic [7:0]   ec;
    model(a, b, int'(ll), s, es, ec);
    send(a, b, ll, s, es, ec, 1'b0);
  endtask

  task automatic idle();
    in_valid_i = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (sbq.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(name, 256'(sbq.size()), 256'(0));
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] rnd256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Monitor: compare every delivered result against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && out_valid_o && out_ready_i) begin
      if (sbq.size() == 0) begin
        check("unexpected_out", 256'(out_valid_o), 256'(0));
      end else begin
        mon_e = sbq.pop_front();
        check("sum", sum_o, mon_e.sum);
        check("carry", 256'(carry_o), 256'(mon_e.cy));
        if (mon_e.chk_lat) check("latency", 256'(cyc - mon_e.acc), 256'(4));
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  logic [255:0] ones, held;
  bit           stable;

  initial begin
    ones = '1;
    in_valid_i = 1'b0; a_i = '0; b_i = '0; lane_log_i = '0; sub_i = 1'b0;
    out_ready_i = 1'b1; rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    check("rst_out_valid", 256'(out_valid_o), 256'(0));
    check("rst_sum", sum_o, 256'(0));
    check("rst_carry", 256'(carry_o), 256'(0));
    check("rst_cnt", 256'(cr_cnt_o), 256'(0));
    check("rst_in_ready", 256'(in_ready_o), 256'(1));
    @(posedge clk); #1;

    // Full-width add with exact latency, then directed lane patterns back-to-back.
    send(ones, 256'd1, 4'd3, 1'b0, 256'd0, 8'h80, 1'b1);
    send({8{32'hFFFF_FFFF}}, {8{32'h0000_0001}}, 4'd0, 1'b0, 256'd0, 8'hFF, 1'b0);
    send(ones, {2{128'd1}}, 4'd2, 1'b0, 256'd0, 8'h88, 1'b0);
    send({4{64'h0000_0000_FFFF_FFFF}}, {4{64'd1}}, 4'd1, 1'b0,
         {4{64'h0000_0001_0000_0000}}, 8'h00, 1'b0);
    if (SUB_EN) send(256'd0, {4{64'd1}}, 4'd1, 1'b1, ones, 8'h00, 1'b0);
    else        send(256'd0, {4{64'd1}}, 4'd1, 1'b1, {4{64'd1}}, 8'h00, 1'b0);
    send(ones, 256'd1, 4'd7, 1'b0, 256'd0, 8'h80, 1'b0);
    idle();
    drain("drain_directed");
    check("cnt_directed", 256'(cr_cnt_o), 256'(6));

    // Reset with three beats in flight.
    send_m(rnd256(), rnd256(), 4'd0, 1'b0);
    send_m(rnd256(), rnd256(), 4'd1, 1'b1);
    send_m(rnd256(), rnd256(), 4'd3, 1'b0);
    idle();
    #2 rst_n = 1'b0;
    sbq.delete();
    #1;
    check("midrst_out_valid", 256'(out_valid_o), 256'(0));
    check("midrst_cnt", 256'(cr_cnt_o), 256'(0));
    @(negedge clk) rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("midrst_quiet", 256'(out_valid_o), 256'(0));
    @(posedge clk); #1;

    // Streaming with a five-cycle output stall.
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          send_m(rnd256(), rnd256(), 4'($urandom_range(0, 4)), 1'($urandom_range(0, 1)));
        end
        idle();
      end
      begin
        repeat (6) @(posedge clk);
        #1 out_ready_i = 1'b0;
        @(negedge clk);
        check("stall_in_ready", 256'(in_ready_o), 256'(0));
        held = sum_o;
        stable = 1'b1;
        repeat (4) begin
          @(negedge clk);
          if (sum_o !== held || !out_valid_o) stable = 1'b0;
        end
        check("stall_hold", 256'(stable), 256'(1));
        @(posedge clk);
        #1 out_ready_i = 1'b1;
      end
    join
    drain("drain_stream");
    check("cnt_stream", 256'(cr_cnt_o), 256'(10));

    // Counter wrap from a preloaded all-ones count.
    @(negedge clk);
    force dut.cr_cnt_q = 32'hFFFF_FFFF;
    #1 release dut.cr_cnt_q;
    #1 check("cnt_preload", 256'(cr_cnt_o), 256'(32'hFFFF_FFFF));
    @(posedge clk); #1;
    send_m(rnd256(), rnd256(), 4'd2, 1'b0);
    idle();
    drain("drain_wrap");
    check("cnt_wrap", 256'(cr_cnt_o), 256'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
